pwm_capture: RTL and testbench
==============================

// Module: pwm_capture
// PURPOSE
//  Receive-side counterpart of the PWM generator. Samples an incoming PWM waveform.
//  Measures its period (rising edge to rising edge) and its high time, both in clock cycles.
//  Publishes each completed measurement with a one-cycle valid strobe.
//  Used for loopback checking of the PWM block and for reading external PWM sensors.
// PARAMETERS
//  WIDTH        8  width of the period/duty counters and outputs
//  SYNC_STAGES  2  flip-flop stages in the input synchronizer (legal range >= 2)
// PORTS
//  clock        in   1      system clock; all logic on rising edge
//  reset        in   1      asynchronous, active-low reset
//  io_en        in   1      capture enable; 0 forces IDLE
//  io_pwmIn     in   1      PWM input; may be asynchronous to clock
//  io_period    out  WIDTH  last measured period, in cycles
//  io_duty      out  WIDTH  last measured high time, in cycles
//  io_valid     out  1      1-cycle pulse: io_period/io_duty were updated this cycle
//  io_timeout   out  1      1-cycle pulse: no edge within 2^WIDTH-1 cycles
// BEHAVIOUR
//  Reset (reset=0, asynchronous):
//   - State = IDLE; counter and captured high time = 0; synchronizer flops = 0.
//   - Outputs: io_period=0, io_duty=0, io_valid=0, io_timeout=0.
//  Input path:
//   - io_pwmIn passes through SYNC_STAGES flops to give s, then one more flop to give s_d.
//   - rise = s & ~s_d; fall = ~s & s_d.
//   - Latency from a pin edge to rise/fall: SYNC_STAGES+1 cycles. It is identical for both
//     edges, so measured widths are exact.
//  FSM states: IDLE, HIGH, LOW.
//   - IDLE: wait for rise. On rise: cnt<=1, go to HIGH. fall is ignored, because the first
//     partial pulse is discarded.
//   - HIGH: cnt<=cnt+1 each cycle.
//     On fall: dcap<=cnt, cnt<=cnt+1, go to LOW.
//   - LOW: cnt<=cnt+1 each cycle.
//     On rise: io_period<=cnt, io_duty<=dcap, io_valid<=1, cnt<=1, go to HIGH.
//  Resulting widths:
//   - Input high D cycles, low P-D cycles -> io_duty=D, io_period=P.
//   - io_valid is registered. It is asserted the cycle after the rise that completes the period.
//  Timeout:
//   - In HIGH or LOW with cnt == 2^WIDTH-1 and no qualifying edge:
//     io_timeout=1 for 1 cycle, go to IDLE, cnt<=0.
//   - io_period and io_duty are unchanged. No valid pulse is generated.
//   - Constant-high and constant-low inputs both end here. The counter never wraps.
//  Enable:
//   - io_en=0 in any state: next state IDLE, cnt<=0, dcap<=0, no strobes.
//   - io_period and io_duty hold their last values. The synchronizer keeps running.
//   - On re-enable, capture restarts at the next rise. The first valid comes after a full period.
//  Simultaneous / boundary cases:
//   - rise and fall are mutually exclusive by construction.
//   - Timeout and an edge in the same cycle: the edge wins.
//   - 100% duty (no fall within the limit) times out from HIGH.
//   - Minimum measurable pulse is 1 cycle high or low, so the minimum period is 2.
//   - Reset asserted mid-measurement aborts immediately. After release the block behaves
//     as from power-up.
//  io_valid and io_timeout are never both 1 in the same cycle.
// TESTING
//  1. io_en=1; input high 3 / low 7 cycles, repeated -> after the 2nd rise:
//     io_valid pulses once per 10 cycles with io_period=10, io_duty=3.
//  2. Input held at 1 for 300 cycles after a rise (WIDTH=8) -> io_timeout pulses at
//     cnt=255; state IDLE; io_period/io_duty unchanged; no io_valid.
//  3. Alternate 1 high / 1 low -> io_period=2, io_duty=1 on every valid. Then 254 high /
//     1 low -> io_period=255, io_duty=254, no timeout.
//  4. Drop io_en mid-pulse for 5 cycles, then re-enable -> no valid while disabled.
//     Outputs keep their prior values. First new valid arrives one full period after the next rise.
//  5. Assert reset in the LOW state mid-period -> io_period=0, io_duty=0, io_valid=0
//     immediately (asynchronous). After release, the first valid arrives only after two rises.
//  6. Drive the PWM generator (period 20, duty 5) into io_pwmIn -> steady
//     io_period=20, io_duty=5.

Source files
------------

// File: rtl/pwm_capture.sv
// PWM capture: synchronizes an external PWM input, measures period (rise to rise) and
// high time in clock cycles, and strobes valid per completed period or timeout on a stall.
module pwm_capture #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_en,
    input  logic             io_pwmIn,
    output logic [WIDTH-1:0] io_period,
    output logic [WIDTH-1:0] io_duty,
    output logic             io_valid,
    output logic             io_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_e;

    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_d_q;
    state_e                 state_q;
    logic [WIDTH-1:0]       cnt_q;
    logic [WIDTH-1:0]       dcap_q;
    logic [WIDTH-1:0]       period_q;
    logic [WIDTH-1:0]       duty_q;
    logic                   valid_q;
    logic                   timeout_q;

    logic                   sync_s;
    logic                   rise_s;
    logic                   fall_s;
    logic [WIDTH-1:0]       cnt_inc_s;
    logic [WIDTH-1:0]       cnt_sat_s;

    assign sync_s    = sync_q[SYNC_STAGES-1];
    assign rise_s    = sync_s & ~s_d_q;
    assign fall_s    = ~sync_s & s_d_q;
    assign cnt_inc_s = cnt_q + CNT_ONE;
    // A fall at the very last count must not wrap into LOW; holding at max lets LOW time out.
    assign cnt_sat_s = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_inc_s;

    // Input synchronizer plus the extra delay flop used for edge detection.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q <= {SYNC_STAGES{1'b0}};
            s_d_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], io_pwmIn};
            s_d_q  <= sync_s;
        end
    end

    // Measurement FSM with registered results and strobes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= {WIDTH{1'b0}};
            dcap_q    <= {WIDTH{1'b0}};
            period_q  <= {WIDTH{1'b0}};
            duty_q    <= {WIDTH{1'b0}};
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            if (!io_en) begin
                state_q <= ST_IDLE;
                cnt_q   <= {WIDTH{1'b0}};
                dcap_q  <= {WIDTH{1'b0}};
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (rise_s) begin
                            cnt_q   <= CNT_ONE;
                            state_q <= ST_HIGH;
                        end else begin
                            cnt_q   <= {WIDTH{1'b0}};
                        end
                    end
                    ST_HIGH: begin
                        if (fall_s) begin
                            dcap_q  <= cnt_q;
                            cnt_q   <= cnt_sat_s;
                            state_q <= ST_LOW;
                        end else if (cnt_q == CNT_MAX) begin
                            timeout_q <= 1'b1;
                            cnt_q     <= {WIDTH{1'b0}};
                            state_q   <= ST_IDLE;
                        end else begin
                            cnt_q <= cnt_inc_s;
                        end
                    end
                    ST_LOW: begin
                        if (rise_s) begin
                            period_q <= cnt_q;
                            duty_q   <= dcap_q;
                            valid_q  <= 1'b1;
                            cnt_q    <= CNT_ONE;
                            state_q  <= ST_HIGH;
                        end else if (cnt_q == CNT_MAX) begin
                            timeout_q <= 1'b1;
                            cnt_q     <= {WIDTH{1'b0}};
                            state_q   <= ST_IDLE;
                        end else begin
                            cnt_q <= cnt_inc_s;
                        end
                    end
                    default: begin
                        cnt_q   <= {WIDTH{1'b0}};
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign io_period  = period_q;
    assign io_duty    = duty_q;
    assign io_valid   = valid_q;
    assign io_timeout = timeout_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: waveforms described as alternating high/low run lengths, with
// expected measurements derived from those lengths by a run-length model.
module tb_pwm_capture;

    logic       clock = 1'b0;
    logic       reset;
    logic       io_en;
    logic       io_pwmIn;
    logic [7:0] io_period;
    logic [7:0] io_duty;
    logic       io_valid;
    logic       io_timeout;

    int errors = 0;
    int checks = 0;

    // Monitor-owned records
    logic [15:0] got_q[$];
    int          got_to     = 0;
    int          both_cnt   = 0;
    int          dis_valid  = 0;

    // Stimulus / model state
    int          seg_q[$];
    logic [15:0] exp_q[$];
    int          exp_to;

    pwm_capture #(.WIDTH(8), .SYNC_STAGES(2)) dut (
        .clock      (clock),
        .reset      (reset),
        .io_en      (io_en),
        .io_pwmIn   (io_pwmIn),
        .io_period  (io_period),
        .io_duty    (io_duty),
        .io_valid   (io_valid),
        .io_timeout (io_timeout)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (io_valid) got_q.push_back({io_period, io_duty});
        if (io_timeout) got_to = got_to + 1;
        if (io_valid && io_timeout) both_cnt = both_cnt + 1;
        if (io_valid && !io_en) dis_valid = dis_valid + 1;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic clean_start();
        reset    = 1'b0;
        io_pwmIn = 1'b0;
        io_en    = 1'b1;
        step(3);
        reset = 1'b1;
        step(4);
    endtask

    // Expected results from run lengths: seg_q = high, low, high, low, ... starting from low.
    task automatic model_segs();
        int hi;
        int lo;
        bit armed;
        hi = 0; lo = 0; armed = 1'b0;
        exp_q.delete();
        exp_to = 0;
        for (int i = 0; i < seg_q.size(); i++) begin
            if (i % 2 == 0) begin
                if (armed) exp_q.push_back({8'(hi + lo), 8'(hi)});
                armed = 1'b1;
                hi    = seg_q[i];
                if (hi > 255) begin
                    exp_to = exp_to + 1;
                    armed  = 1'b0;
                end
            end else if (armed) begin
                lo = seg_q[i];
                if (hi + lo > 255) begin
                    exp_to = exp_to + 1;
                    armed  = 1'b0;
                end
            end
        end
    endtask

    task automatic compare_results(input string name, input int base, input int to_base,
                                   input int both_base);
        int n_got;
        n_got = got_q.size() - base;
        checks++;
        if (n_got != exp_q.size()) begin
            errors++;
            $display("FAIL %s valid_count: got %0d expected %0d", name, n_got, exp_q.size());
        end
        for (int i = 0; i < n_got && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[base+i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s meas[%0d]: got period=%0d duty=%0d expected period=%0d duty=%0d",
                         name, i, got_q[base+i][15:8], got_q[base+i][7:0],
                         exp_q[i][15:8], exp_q[i][7:0]);
            end
        end
        checks++;
        if (got_to - to_base != exp_to) begin
            errors++;
            $display("FAIL %s timeouts: got %0d expected %0d", name, got_to - to_base, exp_to);
        end
        checks++;
        if (both_cnt != both_base) begin
            errors++;
            $display("FAIL %s valid_and_timeout: got %0d expected 0", name, both_cnt - both_base);
        end
    endtask

    task automatic run_segs(input string name);
        int base;
        int to_base;
        int both_base;
        base = got_q.size(); to_base = got_to; both_base = both_cnt;
        model_segs();
        for (int i = 0; i < seg_q.size(); i++) begin
            io_pwmIn = (i % 2 == 0);
            step(seg_q[i]);
        end
        io_pwmIn = 1'b0;
        step(8);
        compare_results(name, base, to_base, both_base);
    endtask

    task automatic test_reset();
        reset = 1'b0; io_en = 1'b1; io_pwmIn = 1'b0;
        step(3);
        checks++; if (io_period !== 8'd0) begin errors++; $display("FAIL reset_period: got %0d expected 0", io_period); end
        checks++; if (io_duty !== 8'd0) begin errors++; $display("FAIL reset_duty: got %0d expected 0", io_duty); end
        checks++; if (io_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", io_valid); end
        checks++; if (io_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %0b expected 0", io_timeout); end
    endtask

    task automatic test_basic();
        clean_start();
        seg_q.delete();
        for (int i = 0; i < 6; i++) begin seg_q.push_back(3); seg_q.push_back(7); end
        seg_q[11] = 300;
        run_segs("basic_3_7");
    endtask

    task automatic test_timeout_high();
        clean_start();
        seg_q.delete();
        seg_q.push_back(3); seg_q.push_back(7);
        seg_q.push_back(300); seg_q.push_back(300);
        run_segs("timeout_high");
        checks++; if (io_period !== 8'd10) begin errors++; $display("FAIL timeout_hold_period: got %0d expected 10", io_period); end
        checks++; if (io_duty !== 8'd3) begin errors++; $display("FAIL timeout_hold_duty: got %0d expected 3", io_duty); end
    endtask

    task automatic test_boundary();
        clean_start();
        seg_q.delete();
        for (int i = 0; i < 10; i++) begin seg_q.push_back(1); seg_q.push_back(1); end
        for (int i = 0; i < 3; i++) begin seg_q.push_back(254); seg_q.push_back(1); end
        seg_q.push_back(1); seg_q.push_back(300);
        run_segs("boundary_min_max");
    endtask

    task automatic test_enable();
        int base;
        int to_base;
        int both_base;
        int dis_base;
        clean_start();
        base = got_q.size(); to_base = got_to; both_base = both_cnt; dis_base = dis_valid;
        io_pwmIn = 1'b0; step(5);
        for (int i = 0; i < 3; i++) begin
            io_pwmIn = 1'b1; step(3);
            io_pwmIn = 1'b0; step(7);
        end
        io_pwmIn = 1'b1; step(1);
        io_en = 1'b0;    step(2);
        io_pwmIn = 1'b0; step(3);
        checks++; if (io_period !== 8'd10) begin errors++; $display("FAIL enable_hold_period: got %0d expected 10", io_period); end
        checks++; if (io_duty !== 8'd3) begin errors++; $display("FAIL enable_hold_duty: got %0d expected 3", io_duty); end
        io_en = 1'b1;    step(4);
        for (int i = 0; i < 3; i++) begin
            io_pwmIn = 1'b1; step(3);
            io_pwmIn = 1'b0; step(7);
        end
        step(300);
        checks++;
        if (dis_valid != dis_base) begin
            errors++;
            $display("FAIL enable_valid_while_disabled: got %0d expected 0", dis_valid - dis_base);
        end
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back({8'd10, 8'd3});
        exp_to = 1;
        compare_results("enable_gap", base, to_base, both_base);
    endtask

    task automatic test_reset_mid();
        int base;
        int to_base;
        int both_base;
        clean_start();
        for (int i = 0; i < 3; i++) begin
            io_pwmIn = 1'b1; step(3);
            io_pwmIn = 1'b0; step(7);
        end
        io_pwmIn = 1'b1; step(3);
        io_pwmIn = 1'b0; step(4);
        #2 reset = 1'b0;
        #1;
        checks++; if (io_period !== 8'd0) begin errors++; $display("FAIL midreset_period: got %0d expected 0", io_period); end
        checks++; if (io_duty !== 8'd0) begin errors++; $display("FAIL midreset_duty: got %0d expected 0", io_duty); end
        checks++; if (io_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %0b expected 0", io_valid); end
        step(3);
        reset = 1'b1;
        step(4);
        base = got_q.size(); to_base = got_to; both_base = both_cnt;
        io_pwmIn = 1'b1; step(3);
        io_pwmIn = 1'b0; step(7);
        checks++;
        if (got_q.size() != base) begin
            errors++;
            $display("FAIL midreset_early_valid: got %0d expected 0", got_q.size() - base);
        end
        io_pwmIn = 1'b1; step(3);
        io_pwmIn = 1'b0; step(7);
        io_pwmIn = 1'b1; step(3);
        io_pwmIn = 1'b0; step(300);
        exp_q.delete();
        exp_q.push_back({8'd10, 8'd3});
        exp_q.push_back({8'd10, 8'd3});
        exp_to = 1;
        compare_results("midreset_restart", base, to_base, both_base);
    endtask

    task automatic test_generator();
        clean_start();
        seg_q.delete();
        for (int i = 0; i < 8; i++) begin seg_q.push_back(5); seg_q.push_back(15); end
        seg_q[15] = 300;
        run_segs("generator_20_5");
    endtask

    task automatic test_random();
        int r;
        int hi;
        int lo;
        clean_start();
        seg_q.delete();
        for (int i = 0; i < 25; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                hi = 256 + $urandom_range(0, 20);
                lo = $urandom_range(1, 10);
            end else if (r == 1) begin
                hi = $urandom_range(1, 100);
                lo = 256 - hi + $urandom_range(0, 20);
            end else begin
                hi = $urandom_range(1, 254);
                lo = $urandom_range(1, 255 - hi);
            end
            seg_q.push_back(hi);
            seg_q.push_back(lo);
        end
        seg_q.push_back(4); seg_q.push_back(300);
        run_segs("random");
    endtask

    initial begin
        reset    = 1'b0;
        io_en    = 1'b0;
        io_pwmIn = 1'b0;
        test_reset();
        test_basic();
        test_timeout_high();
        test_boundary();
        test_enable();
        test_reset_mid();
        test_generator();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
